// File: rtl/parity_pkg.sv
// Shared parity definitions for the transmit framer and the receive-side checker.
// Both ends import this package, so they agree on parity sense and frame layout.
package parity_pkg;

  // Default payload width and the framed width it produces (payload + parity).
  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int FRAME_WIDTH        = DEFAULT_DATA_WIDTH + 1;

  // Widest payload calc_parity accepts. Narrower payloads are zero-extended,
  // and zero-extension leaves the XOR reduction unchanged.
  localparam int MAX_DATA_WIDTH = 256;

  // Skid-buffer occupancy states.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_e;

  // Parity bit that makes the framed word's ones-count even (0) or odd (1).
  function automatic logic calc_parity(input logic [MAX_DATA_WIDTH-1:0] data,
                                       input logic                      even_odd);
    return (^data) ^ even_odd;
  endfunction

endpackage

// File: rtl/parity_frame.sv
// Combinational framer: computes the parity bit of a payload and places it at
// bit 0 or at the top bit of the framed word.
module parity_frame
  import parity_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter bit EVEN_ODD   = 1'b0,
  parameter bit PARITY_BIT = 1'b0
) (
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  corrupt_i,
  output logic [DATA_WIDTH:0]   frame_o
);

  logic parity;

  // corrupt_i inverts the computed parity so the receiver discards the word.
  assign parity = calc_parity(MAX_DATA_WIDTH'(data_i), EVEN_ODD) ^ corrupt_i;

  // Place the parity bit at the selected end of the frame.
  generate
    if (PARITY_BIT) begin : g_parity_top
      assign frame_o = {parity, data_i};
    end else begin : g_parity_bottom
      assign frame_o = {data_i, parity};
    end
  endgenerate

endmodule

// File: rtl/parity_tx.sv
// Transmit-side parity framer. Frames producer words with a parity bit and
// hands them to the FIFO through a 2-entry skid buffer, so outputs are
// registered and one word per cycle is sustained under a continuous grant.
module parity_tx
  import parity_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter bit EVEN_ODD   = 1'b0,
  parameter bit PARITY_BIT = 1'b0,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  valid_i,
  input  logic                  corrupt_i,
  output logic                  grant_o,
  output logic [DATA_WIDTH:0]   data_o,
  output logic                  valid_o,
  input  logic                  grant_i,
  output logic [CNT_WIDTH-1:0]  tx_count_o,
  output logic [CNT_WIDTH-1:0]  err_count_o
);

  localparam logic [1:0] S_EMPTY = EMPTY;
  localparam logic [1:0] S_ONE   = ONE;
  localparam logic [1:0] S_TWO   = TWO;

  logic [1:0]           state_q,   state_d;
  logic [DATA_WIDTH:0]  out_q,     out_d;
  logic [DATA_WIDTH:0]  skid_q,    skid_d;
  logic [CNT_WIDTH-1:0] tx_cnt_q,  tx_cnt_d;
  logic [CNT_WIDTH-1:0] err_cnt_q, err_cnt_d;
  logic [DATA_WIDTH:0]  framed;
  logic                 accept;
  logic                 pop;

  parity_frame #(
    .DATA_WIDTH (DATA_WIDTH),
    .EVEN_ODD   (EVEN_ODD),
    .PARITY_BIT (PARITY_BIT)
  ) u_frame (
    .data_i    (data_i),
    .corrupt_i (corrupt_i),
    .frame_o   (framed)
  );

  // Handshake flags are decoded from registered state only; grant is held low during reset.
  assign valid_o = (state_q != S_EMPTY);
  assign grant_o = (state_q != S_TWO) & ~rst;
  assign data_o  = out_q;
  assign accept  = valid_i & grant_o;
  assign pop     = valid_o & grant_i;

  // Skid-buffer next state: OUT always holds the oldest word, SKID the second one.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned and no latch is inferred.
    state_d = state_q;
    out_d   = out_q;
    skid_d  = skid_q;
    case (state_q)
      S_EMPTY: begin
        if (accept) begin
          out_d   = framed;
          state_d = S_ONE;
        end
      end
      S_ONE: begin
        if (accept && pop) begin
          out_d = framed;
        end else if (accept) begin
          skid_d  = framed;
          state_d = S_TWO;
        end else if (pop) begin
          state_d = S_EMPTY;
        end
      end
      S_TWO: begin
        if (pop) begin
          out_d   = skid_q;
          state_d = S_ONE;
        end
      end
      default: state_d = S_EMPTY;
    endcase
  end

  // Status counters wrap naturally at 2^CNT_WIDTH.
  always_comb begin
    tx_cnt_d  = tx_cnt_q  + (pop ? CNT_WIDTH'(1) : '0);
    err_cnt_d = err_cnt_q + ((accept && corrupt_i) ? CNT_WIDTH'(1) : '0);
  end

  // State, data and counter registers; reset discards any buffered words.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_EMPTY;
      out_q     <= '0;
      skid_q    <= '0;
      tx_cnt_q  <= '0;
      err_cnt_q <= '0;
    end else begin
      // NOTE: non-blocking assignments let every register sample the pre-edge values together.
      state_q   <= state_d;
      out_q     <= out_d;
      skid_q    <= skid_d;
      tx_cnt_q  <= tx_cnt_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign tx_count_o  = tx_cnt_q;
  assign err_count_o = err_cnt_q;

endmodule

// File: doc/parity_tx.md
# parity_tx

Transmit-side framer for the parity-protected FIFO path. Accepts raw DATA_WIDTH-bit words from a producer over a valid/grant handshake and computes the parity bit. It presents DATA_WIDTH+1-bit framed words to the FIFO input (`data_i`/`valid_i`/`grant_o` of the FIFO) through a 2-entry skid buffer, so it sustains one word per cycle with registered outputs. An error-injection input deliberately flips parity so the downstream parity checker's discard path can be exercised.

## Interface
- `DATA_WIDTH`, 32, payload width; the framed word is DATA_WIDTH+1 bits.
- `EVEN_ODD`, 0, parity sense: 0 = even (total ones in the framed word even), 1 = odd.
- `PARITY_BIT`, 0, parity placement: 0 = bit 0, payload in [DATA_WIDTH:1]; 1 = bit DATA_WIDTH, payload in [DATA_WIDTH-1:0].
- `CNT_WIDTH`, 16, width of the status counters.

Ports:
- `clk`  in  1  single clock, all state on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `data_i`  in  DATA_WIDTH  raw payload from producer.
- `valid_i`  in  1  producer has a word.
- `corrupt_i`  in  1  sampled with `data_i`; inverts the computed parity bit of that word.
- `grant_o`  out  1  framer can accept a word this cycle.
- `data_o`  out  DATA_WIDTH+1  framed word toward the FIFO.
- `valid_o`  out  1  `data_o` holds a framed word.
- `grant_i`  in  1  FIFO accepts `data_o` this cycle.
- `tx_count_o`  out  CNT_WIDTH  words delivered downstream, wraps.
- `err_count_o`  out  CNT_WIDTH  corrupted words accepted, wraps.

## Operation
- Accept = `valid_i & grant_o` at a rising edge. Pop = `valid_o & grant_i` at a rising edge.
- Parity computation: p = ^`data_i` XOR EVEN_ODD XOR `corrupt_i`. The framed word is p concatenated with `data_i` at the position selected by PARITY_BIT.
- Storage: output register OUT (drives `data_o`) and skid register SKID.
- FSM states:
  - EMPTY: `valid_o`=0, `grant_o`=1.
  - ONE: OUT valid, `grant_o`=1.
  - TWO: OUT and SKID valid, `grant_o`=0.
- Transitions:
  - EMPTY: accept -> ONE (OUT <= framed); otherwise stay.
  - ONE, accept & pop -> ONE (OUT <= framed).
  - ONE, accept & !pop -> TWO (SKID <= framed).
  - ONE, !accept & pop -> EMPTY.
  - ONE, neither -> ONE.
  - TWO: pop -> ONE (OUT <= SKID); no accept is possible; otherwise hold.
- `valid_o` = (state != EMPTY). `grant_o` = (state != TWO) & !`rst`. Both are decoded from registered state only, with no combinational path from `grant_i` or `valid_i`.
- While `valid_o`=1 and the FIFO has not granted, `data_o` is held stable.
- Counters:
  - `tx_count_o` +1 per pop.
  - `err_count_o` +1 per accept with `corrupt_i`=1.
  - Both wrap modulo 2^CNT_WIDTH.

## Timing
- Reset (async assert, sync release into the next edge):
  - state = EMPTY, `valid_o`=0, `grant_o`=0 while `rst` is high, then 1.
  - `data_o`=0, both counters 0, SKID=0.
- Latency: a word accepted at edge N is on `data_o` with `valid_o`=1 after edge N, and is poppable at edge N+1.
- Throughput: 1 word/cycle while `grant_i`=1 continuously, with the state staying in ONE.
- Backpressure: with `grant_i`=0, the block absorbs exactly 2 words, then `grant_o` drops after the edge that fills SKID.
- Simultaneous accept and pop in ONE: no bubble, and the count does not change.
- Reset mid-transfer: buffered words are discarded and counters cleared. Words dropped this way are not counted in `tx_count_o`.
- Counter wrap: `tx_count_o` = 2^CNT_WIDTH-1 plus one pop -> 0, with no flag.

## Structure
- Package `parity_pkg`:
  - state enum {EMPTY, ONE, TWO}.
  - function `calc_parity(data, even_odd)`.
  - constant for framed width.
  - This package is shared with the receiver-side parity checker so both ends agree on parity sense and placement.
- Sub-module `parity_frame`: combinational framing of payload + parity at PARITY_BIT, instantiated once in front of the skid buffer.

## Test plan
- Reset: assert `rst` for 2 cycles mid-stream with 2 words buffered -> `valid_o`=0, `grant_o`=0 during reset, counters 0, `grant_o`=1 on the first edge after release.
- Framing, with DATA_WIDTH=32, EVEN_ODD=0, PARITY_BIT=0, `grant_i`=1:
  - `data_i`=0x00000003 -> `data_o`=0x0_00000006.
  - `data_i`=0x00000001 -> `data_o`=0x0_00000003.
  - With PARITY_BIT=1, 0x00000001 -> 0x1_00000001.
- Corruption: `data_i`=0x00000003 with `corrupt_i`=1 -> `data_o`=0x0_00000007, `err_count_o`=1; the FIFO parity checker drops the word.
- Backpressure: hold `grant_i`=0 and drive 3 words 0xA, 0xB, 0xC back-to-back -> 0xA and 0xB accepted, `grant_o`=0 after the second accept, 0xC held off. Release `grant_i` -> data order 0xA, 0xB, 0xC, `tx_count_o`=3.
- Streaming: 30 consecutive words with `valid_i`=`grant_i`=1 -> one `data_o` per cycle after 1-cycle latency, no bubbles, `tx_count_o`=30.
- Random stalls: 200 words with random `valid_i`/`grant_i` (50%) into the FIFO -> scoreboard order and parity match exactly, and the FIFO never overflows.
